rbm_sequencer: RTL

- Synthesizable controller that sequences the RBM datapath (`Main`) through one full inference iteration, repeated `iteration_num` times.
- Per iteration:
  - Hidden phase: for every hidden unit, walk every visible pixel, then apply the bias.
  - Classifier phase: for every class, walk every hidden bit, then apply the bias.
- Buffers hidden results internally and accumulates per-class spike counts across iterations.
- Sits between the weight/bias/image memories (combinational read) and `Main`.

---
 rtl/rbm_seq_pkg.sv | 34 +++
 rtl/rbm_sequencer_if.sv | 62 ++++++
 rtl/rbm_spike_accum.sv | 48 ++++
 rtl/rbm_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rbm_seq_pkg.sv
// rbm_seq_pkg
//   Shared definitions for the RBM sequencer slice.
//   - seq_state_e  : sequencer state encoding (IDLE, HID, CLS, DONE)
//   - DEF_*        : default network dimensions and word widths
//   - PIX_W/HID_W/CLS_W : index widths, wide enough to also address the
//                    bias step that follows the last real index of each walk.
//   Optional build macro used elsewhere in this slice: RBM_SEQ_PERF_EN.
package rbm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_CLS  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int DEF_N_VISIBLE = 784;
  localparam int DEF_N_HIDDEN  = 441;
  localparam int DEF_N_CLASS   = 10;
  localparam int DEF_W_BITS    = 12;
  localparam int DEF_ITER_BITS = 8;
  localparam int DEF_CNT_BITS  = 8;

  // +1 so that the bias step (index == N) is representable.
  localparam int PIX_W = $clog2(DEF_N_VISIBLE + 1);
  localparam int HID_W = $clog2(DEF_N_HIDDEN + 1);
  localparam int CLS_W = $clog2(DEF_N_CLASS + 1);

  // True while the sequencer is walking either phase.
  function automatic logic is_active(seq_state_e s);
    return (s == ST_HID) || (s == ST_CLS);
  endfunction

endpackage

// File: rtl/rbm_sequencer_if.sv
// rbm_sequencer_if
//   Bundles the sequencer's run handshake, the memory read bus and the
//   operand/result bus towards the Main datapath.
//   Handshake : start, iteration_num -> busy, done
//   Memories  : pixel_id, hidden_id, spike_id -> img_bit, h_weight_rd,
//               h_bias_rd, c_weight_rd, c_bias_rd (combinational read)
//   Main      : Hvalue, pixel, Cvalue, hidden_pixel, enable_hidden,
//               enable_classi, acc_clear -> hidden, spike
//   modport master : the sequencer
//   modport slave  : the surrounding memories / Main / run controller
interface rbm_sequencer_if
  import rbm_seq_pkg::*;
#(
  parameter int W_BITS    = DEF_W_BITS,
  parameter int ITER_BITS = DEF_ITER_BITS
);

  logic                 start;
  logic [ITER_BITS-1:0] iteration_num;
  logic                 busy;
  logic                 done;

  logic [PIX_W-1:0]     pixel_id;
  logic [HID_W-1:0]     hidden_id;
  logic [CLS_W-1:0]     spike_id;
  logic                 img_bit;
  logic [W_BITS-1:0]    h_weight_rd;
  logic [W_BITS-1:0]    h_bias_rd;
  logic [W_BITS-1:0]    c_weight_rd;
  logic [W_BITS-1:0]    c_bias_rd;

  logic [W_BITS-1:0]    Hvalue;
  logic                 pixel;
  logic [W_BITS-1:0]    Cvalue;
  logic                 hidden_pixel;
  logic                 enable_hidden;
  logic                 enable_classi;
  logic                 acc_clear;
  logic                 hidden;
  logic                 spike;

  modport master (
    input  start, iteration_num,
    input  img_bit, h_weight_rd, h_bias_rd, c_weight_rd, c_bias_rd,
    input  hidden, spike,
    output busy, done,
    output pixel_id, hidden_id, spike_id,
    output Hvalue, pixel, Cvalue, hidden_pixel,
    output enable_hidden, enable_classi, acc_clear
  );

  modport slave (
    output start, iteration_num,
    output img_bit, h_weight_rd, h_bias_rd, c_weight_rd, c_bias_rd,
    output hidden, spike,
    input  busy, done,
    input  pixel_id, hidden_id, spike_id,
    input  Hvalue, pixel, Cvalue, hidden_pixel,
    input  enable_hidden, enable_classi, acc_clear
  );

endinterface

// File: rtl/rbm_spike_accum.sv
// rbm_spike_accum
//   Bank of N_CLASS saturating spike counters.
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero every counter (new run)
//   inc_en       : class bias cycle; counter class_idx adds spike
//   class_idx    : class being finished
//   spike        : Main spike result for that class
//   counts       : class k at bits [k*CNT_BITS +: CNT_BITS]
module rbm_spike_accum
  import rbm_seq_pkg::*;
#(
  parameter int N_CLASS  = DEF_N_CLASS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        inc_en,
  input  logic [CLS_W-1:0]            class_idx,
  input  logic                        spike,
  output logic [N_CLASS*CNT_BITS-1:0] counts
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  genvar gi;
  generate
    for (gi = 0; gi < N_CLASS; gi++) begin : g_cls
      logic [CNT_BITS-1:0] cnt_reg;
      logic                bump;

      // Saturate: once a counter hits all-ones further spikes are dropped.
      assign bump = inc_en && spike && (class_idx == CLS_W'(gi)) &&
                    (cnt_reg != CNT_MAX);

      always_ff @(posedge clock) begin
        if (reset || clear) begin
          cnt_reg <= '0;
        end else if (bump) begin
          cnt_reg <= cnt_reg + CNT_BITS'(1);
        end
      end

      assign counts[gi*CNT_BITS +: CNT_BITS] = cnt_reg;
    end
  endgenerate

endmodule

// File: rtl/rbm_sequencer.sv
// rbm_sequencer
//   Steps the RBM datapath through iteration_num inference iterations.
//   Each iteration: hidden phase (per unit: all visible pixels, then bias),
//   then classifier phase (per class: all hidden bits, then bias). Hidden
//   results are buffered locally; per-class spikes are counted across
//   iterations in rbm_spike_accum.
//   Ports:
//     clock, reset : clock, synchronous active-high reset
//     bus          : rbm_sequencer_if.master (handshake, memory, Main)
//     counts       : per-class spike counts, class k at [k*CNT_BITS +: CNT_BITS]
//     cycle_count  : busy-cycle counter, present only with RBM_SEQ_PERF_EN
module rbm_sequencer
  import rbm_seq_pkg::*;
#(
  parameter int N_VISIBLE = DEF_N_VISIBLE,
  parameter int N_HIDDEN  = DEF_N_HIDDEN,
  parameter int N_CLASS   = DEF_N_CLASS,
  parameter int W_BITS    = DEF_W_BITS,
  parameter int ITER_BITS = DEF_ITER_BITS,
  parameter int CNT_BITS  = DEF_CNT_BITS
) (
  input  logic                        clock,
  input  logic                        reset,
  rbm_sequencer_if.master             bus,
  output logic [N_CLASS*CNT_BITS-1:0] counts
`ifdef RBM_SEQ_PERF_EN
  ,
  output logic [31:0]                 cycle_count
`endif
);

  // Bias step sits one past the last real index of each walk.
  localparam logic [PIX_W-1:0] PIX_BIAS  = PIX_W'(N_VISIBLE);
  localparam logic [HID_W-1:0] HID_LAST  = HID_W'(N_HIDDEN - 1);
  localparam logic [HID_W-1:0] HID_BIAS  = HID_W'(N_HIDDEN);
  localparam logic [CLS_W-1:0] CLS_LAST  = CLS_W'(N_CLASS - 1);

  seq_state_e           state_reg, state_next;
  logic [PIX_W-1:0]     pix_reg;
  logic [HID_W-1:0]     hid_reg;
  logic [CLS_W-1:0]     cls_reg;
  logic [ITER_BITS-1:0] iter_reg;
  logic [ITER_BITS-1:0] target_reg;
  logic [N_HIDDEN-1:0]  hbuf_reg;

  logic start_accept;
  logic hid_bias_cyc;
  logic hid_phase_end;
  logic cls_bias_cyc;
  logic cls_phase_end;
  logic more_iters;
  logic hbuf_bit;
  logic [W_BITS-1:0] hvalue_next;
  logic [W_BITS-1:0] cvalue_next;

  assign start_accept  = (state_reg == ST_IDLE) && bus.start;
  assign hid_bias_cyc  = (state_reg == ST_HID) && (pix_reg == PIX_BIAS);
  assign hid_phase_end = hid_bias_cyc && (hid_reg == HID_LAST);
  assign cls_bias_cyc  = (state_reg == ST_CLS) && (hid_reg == HID_BIAS);
  assign cls_phase_end = cls_bias_cyc && (cls_reg == CLS_LAST);
  // Decided on the last class bias cycle, before iter_reg is bumped.
  assign more_iters    = ({1'b0, iter_reg} + (ITER_BITS + 1)'(1)) <
                         {1'b0, target_reg};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_HID;
      ST_HID:  if (hid_phase_end) state_next = ST_CLS;
      ST_CLS:  if (cls_phase_end) state_next = more_iters ? ST_HID : ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // hbuf lookup for the classifier walk; the bias step reads nothing.
  always_comb begin
    hbuf_bit = 1'b0;
    for (int i = 0; i < N_HIDDEN; i++) begin
      if (hid_reg == HID_W'(i)) hbuf_bit = hbuf_reg[i];
    end
  end

  always_comb begin
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.enable_hidden = 1'b0;
    bus.enable_classi = 1'b0;
    bus.acc_clear     = 1'b0;
    bus.pixel         = 1'b0;
    bus.hidden_pixel  = 1'b0;
    hvalue_next       = '0;
    cvalue_next       = '0;
    case (state_reg)
      ST_HID: begin
        bus.busy          = 1'b1;
        bus.enable_hidden = 1'b1;
        bus.acc_clear     = (pix_reg == '0);
        if (hid_bias_cyc) begin
          bus.pixel   = 1'b1;
          hvalue_next = bus.h_bias_rd;
        end else begin
          bus.pixel   = bus.img_bit;
          hvalue_next = bus.h_weight_rd;
        end
      end
      ST_CLS: begin
        bus.busy          = 1'b1;
        bus.enable_classi = 1'b1;
        bus.acc_clear     = (hid_reg == '0);
        if (cls_bias_cyc) begin
          bus.hidden_pixel = 1'b1;
          cvalue_next      = bus.c_bias_rd;
        end else begin
          bus.hidden_pixel = hbuf_bit;
          cvalue_next      = bus.c_weight_rd;
        end
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Hvalue    = hvalue_next;
  assign bus.Cvalue    = cvalue_next;
  // Counters return to 0 at each phase boundary, so the address outputs
  // are naturally 0 outside the phase that uses them.
  assign bus.pixel_id  = pix_reg;
  assign bus.hidden_id = hid_reg;
  assign bus.spike_id  = cls_reg;

  // ------------------------------------------------------ index counters
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_reg    <= '0;
      hid_reg    <= '0;
      cls_reg    <= '0;
      iter_reg   <= '0;
      target_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            pix_reg    <= '0;
            hid_reg    <= '0;
            cls_reg    <= '0;
            iter_reg   <= '0;
            // A zero request still runs one iteration.
            target_reg <= (bus.iteration_num == '0) ? ITER_BITS'(1)
                                                    : bus.iteration_num;
          end
        end
        ST_HID: begin
          if (hid_bias_cyc) begin
            pix_reg <= '0;
            hid_reg <= (hid_reg == HID_LAST) ? '0 : hid_reg + HID_W'(1);
          end else begin
            pix_reg <= pix_reg + PIX_W'(1);
          end
        end
        ST_CLS: begin
          if (cls_bias_cyc) begin
            hid_reg <= '0;
            if (cls_reg == CLS_LAST) begin
              cls_reg  <= '0;
              iter_reg <= iter_reg + ITER_BITS'(1);
            end else begin
              cls_reg <= cls_reg + CLS_W'(1);
            end
          end else begin
            hid_reg <= hid_reg + HID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Hidden result is captured at the edge that closes the unit's bias cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      hbuf_reg <= '0;
    end else if (hid_bias_cyc) begin
      for (int i = 0; i < N_HIDDEN; i++) begin
        if (hid_reg == HID_W'(i)) hbuf_reg[i] <= bus.hidden;
      end
    end
  end

  rbm_spike_accum #(
    .N_CLASS  (N_CLASS),
    .CNT_BITS (CNT_BITS)
  ) u_accum (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_accept),
    .inc_en    (cls_bias_cyc),
    .class_idx (cls_reg),
    .spike     (bus.spike),
    .counts    (counts)
  );

`ifdef RBM_SEQ_PERF_EN
  logic [31:0] cycle_count_reg;

  always_ff @(posedge clock) begin
    if (reset || start_accept) begin
      cycle_count_reg <= '0;
    end else if (is_active(state_reg)) begin
      cycle_count_reg <= cycle_count_reg + 32'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
`endif

endmodule
